// File: rtl/regfile_pkg.sv
// Shared register-file constants and writeback-source types.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_WB_SRC = 2;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    SRC0 = 1'b0,
    SRC1 = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Small synchronous writeback FIFO; exposes per-entry valid/addr for
// pending-write lookups.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int WIDTH = 37
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_din,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_head,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [DEPTH-1:0]      o_ent_valid,
  output logic [DEPTH*AW-1:0]   o_ent_addr
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW:0]      cnt_q, cnt_d;

  always_comb begin
    mem_d  = mem_q;
    vld_d  = vld_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (i_push) begin
      mem_d[wptr_q] = i_din;
      vld_d[wptr_q] = 1'b1;
      wptr_d        = wptr_q + PW'(1);
    end
    if (i_pop) begin
      vld_d[rptr_q] = 1'b0;
      rptr_d        = rptr_q + PW'(1);
    end
    case ({i_push, i_pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      vld_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      vld_q  <= vld_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_head      = mem_q[rptr_q];
  assign o_empty     = (cnt_q == '0);
  assign o_full      = (cnt_q == (PW+1)'(DEPTH));
  assign o_ent_valid = vld_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign o_ent_addr[g*AW +: AW] = mem_q[g][WIDTH-1 -: AW];
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the
// ALU/load pipe (src0) and the mul/div unit (src1), with hazard lookups.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W     = REG_DATA_W,
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_s0_valid,
  input  logic [ADDR_W-1:0] i_s0_addr,
  input  logic [DATA_W-1:0] i_s0_data,
  output logic              o_s0_ready,
  input  logic              i_s1_valid,
  input  logic [ADDR_W-1:0] i_s1_addr,
  input  logic [DATA_W-1:0] i_s1_data,
  output logic              o_s1_ready,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [DATA_W-1:0] o_wdata,
  input  logic [ADDR_W-1:0] i_raddr1,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic              o_busy1,
  output logic              o_busy2
);

  localparam int EW = ADDR_W + DATA_W;
  localparam int NE = 2 * FIFO_DEPTH;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  logic              push0, push1, pop0, pop1;
  logic              empty0, empty1, full0, full1;
  logic [EW-1:0]     head0, head1, head;
  logic [NE-1:0]     ent_v;
  logic [NE*ADDR_W-1:0] ent_a;

  logic              gnt_vld;
  wb_src_e           gnt;
  wb_src_e           last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              hit1, hit2;

  assign o_s0_ready = !full0;
  assign o_s1_ready = !full1;
  assign push0 = i_s0_valid && o_s0_ready && (i_s0_addr != ZERO);
  assign push1 = i_s1_valid && o_s1_ready && (i_s1_addr != ZERO);

  wb_fifo #(.DEPTH(FIFO_DEPTH), .AW(ADDR_W), .WIDTH(EW)) u_fifo0 (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (push0),
    .i_din       ({i_s0_addr, i_s0_data}),
    .i_pop       (pop0),
    .o_head      (head0),
    .o_empty     (empty0),
    .o_full      (full0),
    .o_ent_valid (ent_v[FIFO_DEPTH-1:0]),
    .o_ent_addr  (ent_a[FIFO_DEPTH*ADDR_W-1:0])
  );

  wb_fifo #(.DEPTH(FIFO_DEPTH), .AW(ADDR_W), .WIDTH(EW)) u_fifo1 (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (push1),
    .i_din       ({i_s1_addr, i_s1_data}),
    .i_pop       (pop1),
    .o_head      (head1),
    .o_empty     (empty1),
    .o_full      (full1),
    .o_ent_valid (ent_v[NE-1:FIFO_DEPTH]),
    .o_ent_addr  (ent_a[NE*ADDR_W-1:FIFO_DEPTH*ADDR_W])
  );

  // last_q records the most recent grant; contention goes to the other one
  always_comb begin
    gnt_vld = !empty0 || !empty1;
    if (!empty0 && !empty1) gnt = (last_q == SRC0) ? SRC1 : SRC0;
    else if (!empty1)       gnt = SRC1;
    else                    gnt = SRC0;
    pop0    = gnt_vld && (gnt == SRC0);
    pop1    = gnt_vld && (gnt == SRC1);
    head    = (gnt == SRC1) ? head1 : head0;
    last_d  = gnt_vld ? gnt : last_q;
    we_d    = gnt_vld;
    waddr_d = gnt_vld ? head[EW-1 -: ADDR_W] : waddr_q;
    wdata_d = gnt_vld ? head[DATA_W-1:0] : wdata_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_q  <= SRC0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      last_q  <= last_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign o_we    = we_q;
  assign o_waddr = waddr_q;
  assign o_wdata = wdata_q;

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < NE; i++) begin
      if (ent_v[i] && ent_a[i*ADDR_W +: ADDR_W] == i_raddr1) hit1 = 1'b1;
      if (ent_v[i] && ent_a[i*ADDR_W +: ADDR_W] == i_raddr2) hit2 = 1'b1;
    end
    if (push0 && i_s0_addr == i_raddr1) hit1 = 1'b1;
    if (push0 && i_s0_addr == i_raddr2) hit2 = 1'b1;
    if (push1 && i_s1_addr == i_raddr1) hit1 = 1'b1;
    if (push1 && i_s1_addr == i_raddr2) hit2 = 1'b1;
    if (we_q && waddr_q == i_raddr1) hit1 = 1'b1;
    if (we_q && waddr_q == i_raddr2) hit2 = 1'b1;
    o_busy1 = hit1 && (i_raddr1 != ZERO);
    o_busy2 = hit2 && (i_raddr2 != ZERO);
  end

endmodule
